riio_gpi_filter_bank: RTL

- Multi-channel, clocked input conditioning stage that sits between a bank of pull-up GPI pad receivers and core logic.
- Per channel it provides:
  - input-enable gating
  - metastability synchronisation
  - programmable digital glitch filter (debounce)
  - edge detection with sticky event flags
- All channel events are aggregated into one interrupt line. This is the parametrised successor to the fixed single-input pull-up receiver cell.

---
 rtl/riio_gpi_filter_bank_pkg.sv | 23 ++
 rtl/riio_gpi_filter_bank_if.sv | 29 ++
 rtl/riio_gpi_filter_ch.sv | 71 +++++++
 rtl/riio_gpi_filter_bank.sv | 42 ++++
 4 files changed

// File: rtl/riio_gpi_filter_bank_pkg.sv
// Shared types and defaults for the GPI input conditioning bank.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package riio_gpi_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  localparam int NUM_CH_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 8;

  // True when a level update in the given direction is one the channel wants to log.
  function automatic logic edge_hit(edge_sel_e sel, logic rise, logic fall);
    return (rise && (sel == EDGE_RISE || sel == EDGE_BOTH)) ||
           (fall && (sel == EDGE_FALL || sel == EDGE_BOTH));
  endfunction

endpackage

// File: rtl/riio_gpi_filter_bank_if.sv
// Control/status bundle between core logic and the GPI filter bank.
// Latency: n/a (wires only).
// Backpressure: none; level and pulse signals, no handshake.
interface riio_gpi_filter_bank_if
  import riio_gpi_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic [NUM_CH-1:0]   pad_di;
  logic [NUM_CH-1:0]   ie;
  logic [CNT_W-1:0]    filt_len;
  logic [2*NUM_CH-1:0] edge_sel;
  logic [NUM_CH-1:0]   evt_clr;
  logic [NUM_CH-1:0]   irq_en;
  logic [NUM_CH-1:0]   di;
  logic [NUM_CH-1:0]   evt;
  logic                irq;

  modport master (
    output pad_di, ie, filt_len, edge_sel, evt_clr, irq_en,
    input  di, evt, irq
  );

  modport slave (
    input  pad_di, ie, filt_len, edge_sel, evt_clr, irq_en,
    output di, evt, irq
  );
endinterface

// File: rtl/riio_gpi_filter_ch.sv
// One GPI channel: synchroniser, glitch filter, level register, edge qualify, sticky flag.
// Latency: pad edge to di is SYNC_STAGES+filt_len+1 clocks; evt sets on the same edge as di.
// Backpressure: none; evt stays set until evt_clr, a coincident new edge wins over clear.
module riio_gpi_filter_ch
  import riio_gpi_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,  // legal 2..4
  parameter int   CNT_W       = CNT_W_DEF,
  parameter logic IDLE_VAL    = 1'b1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             pad_di,
  input  logic             ie,
  input  logic [CNT_W-1:0] filt_len,
  input  logic [1:0]       edge_sel,
  input  logic             evt_clr,
  output logic             di,
  output logic             evt
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   di_q;
  logic                   evt_q;
  logic                   sync;
  logic                   differ;
  logic                   update;
  logic                   evt_set;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign differ  = ie && (sync != di_q);
  // >= rather than == so that shrinking filt_len below a running count fires at once.
  assign update  = differ && (cnt_q >= filt_len);
  assign evt_set = edge_hit(edge_sel_e'(edge_sel), update && sync, update && !sync);

  // Metastability chain; keeps running while disabled so re-enable sees the live pad level.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= {SYNC_STAGES{IDLE_VAL}};
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_di};
  end

  // Glitch filter: level follows sync only after filt_len+1 consecutive differing samples.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      di_q  <= IDLE_VAL;
    end else if (!ie) begin
      cnt_q <= '0;
      di_q  <= IDLE_VAL;
    end else if (!differ) begin
      cnt_q <= '0;
    end else if (update) begin
      cnt_q <= '0;
      di_q  <= sync;
    end else begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Sticky event flag; set has priority over write-1-to-clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) evt_q <= 1'b0;
    else         evt_q <= evt_set | (evt_q & ~evt_clr);
  end

  assign di  = di_q;
  assign evt = evt_q;

endmodule

// File: rtl/riio_gpi_filter_bank.sv
// Bank of NUM_CH pull-up GPI conditioning channels with one aggregated interrupt.
// Latency: per channel SYNC_STAGES+filt_len+1 clocks pad to di; irq is combinational from flops.
// Backpressure: none; events are held in sticky flags until software clears them.
module riio_gpi_filter_bank
  import riio_gpi_pkg::*;
#(
  parameter int   NUM_CH      = NUM_CH_DEF,
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   CNT_W       = CNT_W_DEF,
  parameter logic IDLE_VAL    = 1'b1
) (
  input logic                    clk_i,
  input logic                    rstn_i,
  riio_gpi_filter_bank_if.slave  bus
);
  logic [NUM_CH-1:0] di_w;
  logic [NUM_CH-1:0] evt_w;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    riio_gpi_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .IDLE_VAL    (IDLE_VAL)
    ) u_ch (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .pad_di   (bus.pad_di[g]),
      .ie       (bus.ie[g]),
      .filt_len (bus.filt_len),
      .edge_sel (bus.edge_sel[2*g+1:2*g]),
      .evt_clr  (bus.evt_clr[g]),
      .di       (di_w[g]),
      .evt      (evt_w[g])
    );
  end

  assign bus.di  = di_w;
  assign bus.evt = evt_w;
  // Only registered flags feed the OR, so the line cannot glitch on pad activity.
  assign bus.irq = |(evt_w & bus.irq_en);

endmodule
